// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// producing ALU op/operand selects and all register, PC and memory strobes.
module mips_mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        mem_ack,
    output logic [3:0]  aluc,
    output logic [1:0]  alu_a_sel,
    output logic [2:0]  alu_b_sel,
    output logic [1:0]  pc_src,
    output logic        pc_we,
    output logic        ir_we,
    output logic        aluout_we,
    output logic        mdr_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        exc,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [5:0] op, fn;
    logic       unused_instr;
    assign op           = instr[31:26];
    assign fn           = instr[5:0];
    assign unused_instr = ^instr[25:6];

    logic [3:0] d_aluc;
    logic [1:0] d_a;
    logic [2:0] d_b;
    logic       d_legal, d_rtype, d_lw, d_sw, d_beq, d_bne, d_j, d_jal, d_jr, d_ovf;

    always_comb begin
        d_aluc  = 4'b0000;
        d_a     = 2'd1;
        d_b     = 3'd0;
        d_legal = 1'b1;
        d_rtype = 1'b0;
        d_lw    = 1'b0;
        d_sw    = 1'b0;
        d_beq   = 1'b0;
        d_bne   = 1'b0;
        d_j     = 1'b0;
        d_jal   = 1'b0;
        d_jr    = 1'b0;
        d_ovf   = 1'b0;
        case (op)
            6'h00: begin
                d_rtype = 1'b1;
                case (fn)
                    6'h20: begin d_aluc = 4'b0010; d_ovf = 1'b1; end
                    6'h21: d_aluc = 4'b0000;
                    6'h22: begin d_aluc = 4'b0011; d_ovf = 1'b1; end
                    6'h23: d_aluc = 4'b0001;
                    6'h24: d_aluc = 4'b0100;
                    6'h25: d_aluc = 4'b0101;
                    6'h26: d_aluc = 4'b0110;
                    6'h27: d_aluc = 4'b0111;
                    6'h2A: d_aluc = 4'b1011;
                    6'h2B: d_aluc = 4'b1010;
                    6'h00: begin d_aluc = 4'b1110; d_a = 2'd2; end
                    6'h02: begin d_aluc = 4'b1101; d_a = 2'd2; end
                    6'h03: begin d_aluc = 4'b1100; d_a = 2'd2; end
                    6'h04: d_aluc = 4'b1110;
                    6'h06: d_aluc = 4'b1101;
                    6'h07: d_aluc = 4'b1100;
                    6'h08: d_jr = 1'b1;
                    default: d_legal = 1'b0;
                endcase
            end
            6'h08: begin d_aluc = 4'b0010; d_b = 3'd2; d_ovf = 1'b1; end
            6'h09: begin d_aluc = 4'b0000; d_b = 3'd2; end
            6'h0A: begin d_aluc = 4'b1011; d_b = 3'd2; end
            6'h0B: begin d_aluc = 4'b1010; d_b = 3'd2; end
            6'h0C: begin d_aluc = 4'b0100; d_b = 3'd3; end
            6'h0D: begin d_aluc = 4'b0101; d_b = 3'd3; end
            6'h0E: begin d_aluc = 4'b0110; d_b = 3'd3; end
            6'h0F: begin d_aluc = 4'b1000; d_b = 3'd3; end
            6'h23: begin d_aluc = 4'b0000; d_b = 3'd2; d_lw = 1'b1; end
            6'h2B: begin d_aluc = 4'b0000; d_b = 3'd2; d_sw = 1'b1; end
            6'h04: begin d_aluc = 4'b0001; d_beq = 1'b1; end
            6'h05: begin d_aluc = 4'b0001; d_bne = 1'b1; end
            6'h02: d_j   = 1'b1;
            6'h03: d_jal = 1'b1;
            default: d_legal = 1'b0;
        endcase
    end

    // Outputs are a pure decode of state + IR, held at zero while rst is high;
    // only mem_ack and the ALU flags gate strobes in the same cycle.
    always_comb begin
        state_d      = state_q;
        aluc         = 4'b0000;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 3'd0;
        pc_src       = 2'd0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        aluout_we    = 1'b0;
        mdr_we       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 2'd0;
        wb_sel       = 2'd0;
        exc          = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_b_sel = 3'd1;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    aluout_we = 1'b1;
                    alu_b_sel = 3'd4;
                    if (!d_legal) begin
                        state_d = S_TRAP;
                    end else if (d_j || d_jal) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        state_d = S_FETCH;
                        if (d_jal) begin
                            reg_we  = 1'b1;
                            reg_dst = 2'd2;
                            wb_sel  = 2'd2;
                        end
                    end else if (d_jr) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd3;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    aluc      = d_aluc;
                    alu_a_sel = d_a;
                    alu_b_sel = d_b;
                    if (d_beq || d_bne) begin
                        if (d_beq ? alu_zero : !alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                        state_d = S_FETCH;
                    end else if (d_ovf && alu_overflow) begin
                        state_d = S_TRAP;
                    end else begin
                        aluout_we = 1'b1;
                        state_d   = (d_lw || d_sw) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = d_sw;
                    if (mem_ack) begin
                        mdr_we  = d_lw;
                        state_d = d_lw ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = d_rtype ? 2'd1 : 2'd0;
                    wb_sel  = d_lw ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    exc     = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = rst ? 3'd0 : state_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: table of instructions run through a cycle-level
// driver, results scored against queued expectations, plus reset sequences.
module tb_mips_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        alu_zero = 1'b0, alu_overflow = 1'b0, mem_ack = 1'b0;
    logic [3:0]  aluc;
    logic [1:0]  alu_a_sel, pc_src, reg_dst, wb_sel;
    logic [2:0]  alu_b_sel, state;
    logic        pc_we, ir_we, aluout_we, mdr_we, mem_req, mem_we, mem_addr_sel, reg_we, exc;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .mem_ack(mem_ack), .aluc(aluc),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .pc_src(pc_src),
        .pc_we(pc_we), .ir_we(ir_we), .aluout_we(aluout_we), .mdr_we(mdr_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .exc(exc),
        .state(state)
    );

    typedef struct {
        string       name;
        logic [31:0] ins;
        bit          zero, ovf, ack_all;
        int          fwait, mwait;
        bit          chk_alu, chk_a;
        logic [3:0]  aluc;
        logic [1:0]  a;
        logic [2:0]  b;
        int          cyc, n_reg, n_exc, n_pc, n_mdr, n_req, n_addr1, n_mwe;
        logic [1:0]  jsrc, rdst, wbs;
    } vec_t;

    typedef struct {
        int         cyc, n_reg, n_exc, n_pc, n_mdr, n_req, n_addr1, n_mwe;
        logic [3:0] aluc;
        logic [1:0] a;
        logic [2:0] b;
        logic [1:0] jsrc, rdst, wbs;
        bit         saw_exec;
    } res_t;

    int   total = 0, passed = 0;
    vec_t tv[$];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] R(input int rs, rt, rd, sh, f);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], f[5:0]};
    endfunction

    function automatic logic [31:0] I(input int op, rs, rt, imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic vec_t base(input string nm, input logic [31:0] ins);
        vec_t v;
        v.name = nm; v.ins = ins; v.zero = 0; v.ovf = 0; v.ack_all = 0;
        v.fwait = 0; v.mwait = 0; v.chk_alu = 1; v.chk_a = 1;
        v.aluc = 4'b0000; v.a = 2'd1; v.b = 3'd0;
        v.cyc = 4; v.n_reg = 1; v.n_exc = 0; v.n_pc = 1; v.n_mdr = 0;
        v.n_req = 1; v.n_addr1 = 0; v.n_mwe = 0;
        v.jsrc = 2'd0; v.rdst = 2'd1; v.wbs = 2'd0;
        return v;
    endfunction

    // Entered and left at #1 after a rising edge with the DUT in FETCH.
    task automatic run(input vec_t v, output res_t r);
        int         fc, mc;
        bit         seen, done;
        logic [2:0] st;
        r = '{default: 0};
        fc = 0; mc = 0; seen = 0; done = 0;
        instr = v.ins; alu_zero = v.zero; alu_overflow = v.ovf;
        for (int k = 0; k < 40 && !done; k++) begin
            st = state;
            if (v.ack_all)   mem_ack = 1'b1;
            else if (st == 3'd0) mem_ack = (fc == v.fwait);
            else if (st == 3'd3) mem_ack = (mc == v.mwait);
            else             mem_ack = 1'b0;
            #1;
            if (st != 3'd0) seen = 1;
            if (st == 3'd2) begin
                r.saw_exec = 1; r.aluc = aluc; r.a = alu_a_sel; r.b = alu_b_sel;
            end
            if (pc_we) begin r.n_pc += 1; if (st != 3'd0) r.jsrc = pc_src; end
            if (reg_we) begin r.n_reg += 1; r.rdst = reg_dst; r.wbs = wb_sel; end
            if (exc) r.n_exc += 1;
            if (mdr_we) r.n_mdr += 1;
            if (mem_req) r.n_req += 1;
            if (mem_req && mem_addr_sel) r.n_addr1 += 1;
            if (mem_req && mem_we) r.n_mwe += 1;
            if (st == 3'd0) fc++;
            if (st == 3'd3) mc++;
            @(posedge clk); #1;
            r.cyc += 1;
            if (seen && state == 3'd0) done = 1;
        end
        mem_ack = 1'b0;
        chk({v.name, " completes"}, {31'd0, done}, 32'd1);
    endtask

    task automatic compare(input vec_t e, input res_t r);
        chk({e.name, " cycles"}, r.cyc, e.cyc);
        chk({e.name, " reg_we"}, r.n_reg, e.n_reg);
        chk({e.name, " exc"}, r.n_exc, e.n_exc);
        chk({e.name, " pc_we"}, r.n_pc, e.n_pc);
        chk({e.name, " mdr_we"}, r.n_mdr, e.n_mdr);
        chk({e.name, " mem_req"}, r.n_req, e.n_req);
        chk({e.name, " addr_sel"}, r.n_addr1, e.n_addr1);
        chk({e.name, " mem_we"}, r.n_mwe, e.n_mwe);
        if (e.chk_alu) begin
            chk({e.name, " exec"}, {31'd0, r.saw_exec}, 32'd1);
            chk({e.name, " aluc"}, {28'd0, r.aluc}, {28'd0, e.aluc});
            chk({e.name, " b_sel"}, {29'd0, r.b}, {29'd0, e.b});
            if (e.chk_a) chk({e.name, " a_sel"}, {30'd0, r.a}, {30'd0, e.a});
        end
        if (e.n_pc == 2) chk({e.name, " pc_src"}, {30'd0, r.jsrc}, {30'd0, e.jsrc});
        if (e.n_reg > 0) begin
            chk({e.name, " reg_dst"}, {30'd0, r.rdst}, {30'd0, e.rdst});
            chk({e.name, " wb_sel"}, {30'd0, r.wbs}, {30'd0, e.wbs});
        end
    endtask

    function automatic logic [31:0] all_out();
        return {5'd0, aluc, alu_a_sel, alu_b_sel, pc_src, pc_we, ir_we, aluout_we,
                mdr_we, mem_req, mem_we, mem_addr_sel, reg_we, reg_dst, wb_sel, exc, state};
    endfunction

    initial begin
        vec_t v;
        res_t r;

        v = base("add", R(1,2,3,0,'h20));  v.aluc = 4'b0010; tv.push_back(v);
        v = base("add_ovf", R(1,2,3,0,'h20)); v.ovf = 1; v.aluc = 4'b0010;
        v.n_reg = 0; v.n_exc = 1; tv.push_back(v);
        v = base("subu_ovf", R(1,2,3,0,'h23)); v.ovf = 1; v.aluc = 4'b0001; tv.push_back(v);
        v = base("nor", R(1,2,3,0,'h27));  v.aluc = 4'b0111; tv.push_back(v);
        v = base("sltu", R(1,2,3,0,'h2B)); v.aluc = 4'b1010; tv.push_back(v);
        v = base("sll", R(0,2,3,4,'h00));  v.aluc = 4'b1110; v.a = 2'd2; tv.push_back(v);
        v = base("sra", R(0,2,3,4,'h03));  v.aluc = 4'b1100; v.a = 2'd2; tv.push_back(v);
        v = base("srav", R(1,2,3,0,'h07)); v.aluc = 4'b1100; tv.push_back(v);
        v = base("srlv", R(1,2,3,0,'h06)); v.aluc = 4'b1101; tv.push_back(v);
        v = base("lui", I('h0F,0,3,'h1234)); v.aluc = 4'b1000; v.b = 3'd3;
        v.chk_a = 0; v.rdst = 2'd0; tv.push_back(v);
        v = base("ori", I('h0D,1,3,'h00F0)); v.aluc = 4'b0101; v.b = 3'd3;
        v.rdst = 2'd0; tv.push_back(v);
        v = base("addi_ovf", I('h08,1,3,'h7FFF)); v.ovf = 1; v.aluc = 4'b0010;
        v.b = 3'd2; v.n_reg = 0; v.n_exc = 1; tv.push_back(v);
        v = base("addiu_ovf", I('h09,1,3,'h7FFF)); v.ovf = 1; v.b = 3'd2;
        v.rdst = 2'd0; tv.push_back(v);
        v = base("slti", I('h0A,1,3,'hFFFF)); v.aluc = 4'b1011; v.b = 3'd2;
        v.rdst = 2'd0; tv.push_back(v);
        v = base("lw_wait", I('h23,1,3,'h0010)); v.mwait = 2; v.b = 3'd2; v.cyc = 7;
        v.rdst = 2'd0; v.wbs = 2'd1; v.n_mdr = 1; v.n_req = 4; v.n_addr1 = 3; tv.push_back(v);
        v = base("sw", I('h2B,1,3,'h0010)); v.b = 3'd2; v.n_reg = 0; v.n_req = 2;
        v.n_addr1 = 1; v.n_mwe = 1; tv.push_back(v);
        v = base("beq_t", I('h04,1,2,'h0008)); v.zero = 1; v.aluc = 4'b0001; v.cyc = 3;
        v.n_reg = 0; v.n_pc = 2; v.jsrc = 2'd1; tv.push_back(v);
        v = base("beq_nt", I('h04,1,2,'h0008)); v.aluc = 4'b0001; v.cyc = 3;
        v.n_reg = 0; tv.push_back(v);
        v = base("bne_z", I('h05,1,2,'h0008)); v.zero = 1; v.aluc = 4'b0001; v.cyc = 3;
        v.n_reg = 0; tv.push_back(v);
        v = base("bne_t", I('h05,1,2,'h0008)); v.aluc = 4'b0001; v.cyc = 3;
        v.n_reg = 0; v.n_pc = 2; v.jsrc = 2'd1; tv.push_back(v);
        v = base("j", {6'h02, 26'h0123456}); v.chk_alu = 0; v.cyc = 2; v.n_reg = 0;
        v.n_pc = 2; v.jsrc = 2'd2; tv.push_back(v);
        v = base("jal", {6'h03, 26'h0123456}); v.chk_alu = 0; v.cyc = 2; v.n_pc = 2;
        v.jsrc = 2'd2; v.rdst = 2'd2; v.wbs = 2'd2; tv.push_back(v);
        v = base("jr", R(5,0,0,0,'h08)); v.chk_alu = 0; v.cyc = 2; v.n_reg = 0;
        v.n_pc = 2; v.jsrc = 2'd3; tv.push_back(v);
        v = base("ill_op", {6'h3F, 26'd0}); v.chk_alu = 0; v.cyc = 3; v.n_reg = 0;
        v.n_exc = 1; tv.push_back(v);
        v = base("ill_fn", R(1,2,3,0,'h01)); v.chk_alu = 0; v.cyc = 3; v.n_reg = 0;
        v.n_exc = 1; tv.push_back(v);
        v = base("and_fwait", R(1,2,3,0,'h24)); v.fwait = 1; v.aluc = 4'b0100;
        v.cyc = 5; v.n_req = 2; tv.push_back(v);
        v = base("or_ackall", R(1,2,3,0,'h25)); v.ack_all = 1; v.aluc = 4'b0101;
        tv.push_back(v);

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", all_out(), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset state", {29'd0, state}, 32'd0);
        chk("post-reset mem_req", {31'd0, mem_req}, 32'd1);
        chk("post-reset b_sel", {29'd0, alu_b_sel}, 32'd1);

        foreach (tv[i]) begin
            exp_q.push_back(tv[i]);
            run(tv[i], r);
            compare(exp_q.pop_front(), r);
        end

        // Reset while a store waits in MEM
        instr = I('h2B,1,2,'h0004); alu_overflow = 1'b0; alu_zero = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 6 && state != 3'd3; k++) begin
            @(posedge clk); #1;
        end
        chk("sw reaches MEM", {29'd0, state}, 32'd3);
        chk("sw MEM mem_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("rst mid-MEM state", {29'd0, state}, 32'd0);
        chk("rst mid-MEM outputs", all_out(), 32'd0);
        @(posedge clk); #1;
        chk("rst 2nd cycle outputs", all_out(), 32'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("after rst state", {29'd0, state}, 32'd0);
        chk("after rst fetch req", {31'd0, mem_req}, 32'd1);
        chk("after rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("after rst addr_sel", {31'd0, mem_addr_sel}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
